// File: rtl/tilt_decoder.sv
// Tilt decoder: turns signed accelerometer X/Y samples into per-axis
// direction levels. Each axis has a dead zone, hysteresis around the
// committed direction, and a run-length debounce before a new direction
// is committed. Both axes share sample_valid and are otherwise independent.
module tilt_decoder #(
  parameter int DATA_WIDTH   = 12,
  parameter int DEAD_ZONE    = 150,
  parameter int HYST         = 32,
  parameter int STABLE_COUNT = 4,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] accel_x,
  input  logic [DATA_WIDTH-1:0] accel_y,
  output logic                  x_increment,
  output logic                  x_decrement,
  output logic                  y_increment,
  output logic                  y_decrement,
  output logic                  tilt_change
);

  typedef enum logic [1:0] {
    ST_NEUTRAL = 2'd0,
    ST_POS     = 2'd1,
    ST_NEG     = 2'd2
  } axis_state_t;

  // Thresholds are one bit wider than the samples so that negating them and
  // comparing against the most negative sample can never wrap.
  localparam logic signed [DATA_WIDTH:0] POS_ENTER = (DATA_WIDTH+1)'(DEAD_ZONE);
  localparam logic signed [DATA_WIDTH:0] POS_EXIT  = (DATA_WIDTH+1)'(DEAD_ZONE - HYST);
  localparam logic signed [DATA_WIDTH:0] NEG_ENTER = -POS_ENTER;
  localparam logic signed [DATA_WIDTH:0] NEG_EXIT  = -POS_EXIT;
  localparam logic [CNT_WIDTH-1:0]       STABLE_CNT = CNT_WIDTH'(STABLE_COUNT);
  localparam logic [CNT_WIDTH-1:0]       ONE_CNT    = CNT_WIDTH'(1);

  logic signed [DATA_WIDTH:0] sample_ext [2];
  logic [1:0] pos_vec;
  logic [1:0] neg_vec;
  logic [1:0] change_vec;
  logic       tilt_change_reg;

  // Sign-extend the samples; they are never negated, so -2^(DATA_WIDTH-1) is safe.
  assign sample_ext[0] = {accel_x[DATA_WIDTH-1], accel_x};
  assign sample_ext[1] = {accel_y[DATA_WIDTH-1], accel_y};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      axis_state_t                committed_reg;
      axis_state_t                committed_next;
      axis_state_t                cand_reg;
      axis_state_t                cand_next;
      axis_state_t                sample_class;
      logic [CNT_WIDTH-1:0]       count_reg;
      logic [CNT_WIDTH-1:0]       count_next;
      logic signed [DATA_WIDTH:0] pos_thr;
      logic signed [DATA_WIDTH:0] neg_thr;

      // Classify the sample; the committed direction only needs the relaxed
      // exit threshold to hold, the opposite direction needs the full dead zone.
      always_comb begin
        pos_thr      = (committed_reg == ST_POS) ? POS_EXIT : POS_ENTER;
        neg_thr      = (committed_reg == ST_NEG) ? NEG_EXIT : NEG_ENTER;
        sample_class = ST_NEUTRAL;
        if (sample_ext[gi] > pos_thr) begin
          sample_class = ST_POS;
        end else if (sample_ext[gi] < neg_thr) begin
          sample_class = ST_NEG;
        end
      end

      // Debounce: track a candidate class and its saturating run length, and
      // commit the candidate on the same edge its run reaches STABLE_COUNT.
      always_comb begin
        cand_next      = cand_reg;
        count_next     = count_reg;
        committed_next = committed_reg;
        if (sample_valid) begin
          if (sample_class != cand_reg) begin
            cand_next  = sample_class;
            count_next = ONE_CNT;
          end else if (count_reg >= STABLE_CNT) begin
            count_next = STABLE_CNT;
          end else begin
            count_next = count_reg + 1'b1;
          end
          if ((count_next == STABLE_CNT) && (cand_next != committed_reg)) begin
            committed_next = cand_next;
          end
        end
      end

      // Per-axis state registers; reset discards any partial run.
      always_ff @(posedge clk) begin
        if (reset) begin
          committed_reg <= ST_NEUTRAL;
          cand_reg      <= ST_NEUTRAL;
          count_reg     <= '0;
        end else begin
          committed_reg <= committed_next;
          cand_reg      <= cand_next;
          count_reg     <= count_next;
        end
      end

      assign pos_vec[gi]    = (committed_reg == ST_POS);
      assign neg_vec[gi]    = (committed_reg == ST_NEG);
      assign change_vec[gi] = (committed_next != committed_reg);
    end
  endgenerate

  // One pulse in the cycle after any axis commits, merged across axes.
  always_ff @(posedge clk) begin
    if (reset) begin
      tilt_change_reg <= 1'b0;
    end else begin
      tilt_change_reg <= |change_vec;
    end
  end

  assign x_increment = pos_vec[0];
  assign x_decrement = neg_vec[0];
  assign y_increment = pos_vec[1];
  assign y_decrement = neg_vec[1];
  assign tilt_change = tilt_change_reg;

endmodule

// File: tb/tb_tilt_decoder.sv
// Bench for tilt_decoder: directed samples push hand-computed expected
// outputs {x_inc, x_dec, y_inc, y_dec, tilt_change} into a queue; a monitor
// pops and compares just after every edge that registers a valid sample.
module tb_tilt_decoder;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [11:0] accel_x;
  logic [11:0] accel_y;
  logic        x_increment;
  logic        x_decrement;
  logic        y_increment;
  logic        y_decrement;
  logic        tilt_change;

  int total_checks = 0;
  int passed_checks = 0;
  int sample_id = 0;
  int tc_cycles = 0;
  int both_x_cycles = 0;
  int both_y_cycles = 0;

  logic [4:0] exp_q [$];
  int         id_q  [$];

  tilt_decoder #(
    .DATA_WIDTH(12),
    .DEAD_ZONE(150),
    .HYST(32),
    .STABLE_COUNT(4),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .accel_x(accel_x),
    .accel_y(accel_y),
    .x_increment(x_increment),
    .x_decrement(x_decrement),
    .y_increment(y_increment),
    .y_decrement(y_decrement),
    .tilt_change(tilt_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    total_checks++;
    if (got == want) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Monitor: compare the outputs that follow each registered sample.
  always @(posedge clk) begin
    if (sample_valid) begin
      #1;
      if (exp_q.size() == 0) begin
        check("unexpected_sample_output", 1, 0);
      end else begin
        automatic logic [4:0] want = exp_q.pop_front();
        automatic int         id   = id_q.pop_front();
        automatic logic [4:0] got  = {x_increment, x_decrement, y_increment, y_decrement, tilt_change};
        $display("sample %0d: outputs %b required %b", id, got, want);
        check($sformatf("sample_%0d", id), int'(got), int'(want));
      end
    end
  end

  // Per-cycle bookkeeping for pulse counting and mutual exclusion.
  always @(negedge clk) begin
    if (tilt_change) tc_cycles++;
    if (x_increment && x_decrement) both_x_cycles++;
    if (y_increment && y_decrement) both_y_cycles++;
  end

  task automatic send(input int x, input int y, input int gap, input logic [4:0] want);
    @(negedge clk);
    accel_x      = 12'(x);
    accel_y      = 12'(y);
    sample_valid = 1'b1;
    sample_id++;
    exp_q.push_back(want);
    id_q.push_back(sample_id);
    @(negedge clk);
    sample_valid = 1'b0;
    accel_x      = 12'd0;
    accel_y      = 12'd0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles, input string name);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    check({name, "_outputs"}, int'({x_increment, x_decrement, y_increment, y_decrement}), 0);
    check({name, "_tilt_change"}, int'(tilt_change), 0);
    reset = 1'b0;
    $display("reset %s: outputs %b%b%b%b tc %b", name, x_increment, x_decrement,
             y_increment, y_decrement, tilt_change);
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    accel_x      = 12'd0;
    accel_y      = 12'd0;

    do_reset(2, "initial");

    // Three strong samples are one short of committing.
    repeat (3) send(400, 0, 0, 5'b00000);

    // Gaps keep the run alive: the 4th consecutive sample commits POS.
    send(400, 0, 5, 5'b10001);
    repeat (3) send(400, 0, 5, 5'b10000);

    // Hysteresis: 130 holds POS (above 118); exactly 118 drops to NEUTRAL.
    repeat (4) send(130, 0, 0, 5'b10000);
    repeat (3) send(118, 0, 0, 5'b10000);
    send(118, 0, 0, 5'b00001);

    // Glitch rejection: a single neutral sample restarts the run.
    repeat (3) send(400, 0, 0, 5'b00000);
    send(0, 0, 0, 5'b00000);
    repeat (3) send(400, 0, 0, 5'b00000);
    send(400, 0, 0, 5'b10001);

    // Extremes: direct POS->NEG on X and NEUTRAL->POS on Y, same edge, one pulse.
    repeat (4) send(400, 0, 0, 5'b10000);
    repeat (3) send(-2048, 2047, 0, 5'b10000);
    send(-2048, 2047, 0, 5'b01101);

    // Negative-side hysteresis: -119 holds NEG, exactly -118 releases it.
    repeat (4) send(-119, 2047, 0, 5'b01100);
    repeat (3) send(-118, 2047, 0, 5'b01100);
    send(-118, 2047, 0, 5'b00101);

    // Reset mid-debounce discards the partial Y run.
    do_reset(1, "pre_midrun");
    repeat (2) send(0, -400, 0, 5'b00000);
    do_reset(1, "midrun");
    repeat (3) send(0, -400, 0, 5'b00000);
    send(0, -400, 0, 5'b00011);

    repeat (5) @(negedge clk);

    check("pending_expectations", exp_q.size(), 0);
    check("tilt_change_cycles", tc_cycles, 6);
    check("x_both_high_cycles", both_x_cycles, 0);
    check("y_both_high_cycles", both_y_cycles, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
